// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, flag bundle, and the rule that
// decides which opcodes update the architectural flags.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_NOT = 3'b010,
        ALU_AND = 3'b011,
        ALU_OR  = 3'b100,
        ALU_XOR = 3'b101,
        ALU_SLT = 3'b110,
        ALU_EQ  = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic overflow;
        logic carry;
        logic zero;
    } alu_flags_t;

    // Arithmetic and compare ops update flags; logic ops leave them alone.
    function automatic logic alu_sets_flags(input logic [2:0] sel);
        return (sel == ALU_ADD) || (sel == ALU_SUB) ||
               (sel == ALU_SLT) || (sel == ALU_EQ);
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order skid buffer: a main entry that drives the outputs and a
// skid entry that absorbs one extra push while the consumer stalls.
module skid_buf2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    input  logic         i_pop_ready,
    output logic [W-1:0] o_data
);

    logic         r_main_valid;
    logic [W-1:0] r_main_data;
    logic         r_skid_valid;
    logic [W-1:0] r_skid_data;
    logic         w_pop;

    assign w_pop   = r_main_valid & i_pop_ready;
    assign o_ready = ~r_skid_valid;
    assign o_valid = r_main_valid;
    assign o_data  = r_main_data;

    // The producer only pushes while o_ready is high, so a push never meets
    // a full skid entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (w_pop && r_skid_valid) begin
            r_main_data  <= r_skid_data;
            r_skid_valid <= 1'b0;
        end else if (i_push && (!r_main_valid || w_pop)) begin
            r_main_valid <= 1'b1;
            r_main_data  <= i_data;
        end else begin
            if (w_pop) begin
                r_main_valid <= 1'b0;
            end
            if (i_push) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= i_data;
            end
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// Writeback stage after the integer ALU: buffers {rd, result} for the
// register-file write port, keeps the flag register and a retire counter.
// Optional sticky overflow bit enabled by ALU_WB_STICKY_OVF_EN.
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned RD_W  = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_sel,
    input  logic [RD_W-1:0]  in_rd,
    input  logic [WIDTH-1:0] in_result,
    input  logic             in_overflow,
    input  logic             in_carry,
    input  logic             in_zero,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [RD_W-1:0]  wb_rd,
    output logic [WIDTH-1:0] wb_data,
    output logic [2:0]       flags,
    output logic [CNT_W-1:0] retire_cnt
`ifdef ALU_WB_STICKY_OVF_EN
    ,
    input  logic             sticky_clr,
    output logic             sticky_ovf
`endif
);

    logic                  w_accept;
    logic                  w_push;
    logic                  w_write;
    logic                  w_flag_upd;
    logic [RD_W+WIDTH-1:0] w_buf_out;
    alu_flags_t            r_flags;
    logic [CNT_W-1:0]      r_retire_cnt;

    assign w_accept   = in_valid & in_ready;
    assign w_push     = w_accept & (in_rd != '0);
    assign w_write    = wb_valid & wb_ready;
    assign w_flag_upd = w_accept & alu_sets_flags(in_sel);

    skid_buf2 #(
        .W(RD_W + WIDTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_data     ({in_rd, in_result}),
        .o_ready    (in_ready),
        .o_valid    (wb_valid),
        .i_pop_ready(wb_ready),
        .o_data     (w_buf_out)
    );

    assign wb_rd      = w_buf_out[RD_W+WIDTH-1:WIDTH];
    assign wb_data    = w_buf_out[WIDTH-1:0];
    assign flags      = r_flags;
    assign retire_cnt = r_retire_cnt;

    // Flags follow acceptance, so results to r0 still update them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (w_flag_upd) begin
            r_flags <= '{overflow: in_overflow, carry: in_carry, zero: in_zero};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (w_write) begin
            r_retire_cnt <= r_retire_cnt + 1'b1;
        end
    end

`ifdef ALU_WB_STICKY_OVF_EN
    logic r_sticky_ovf;

    assign sticky_ovf = r_sticky_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky_ovf <= 1'b0;
        end else if (w_flag_upd && in_overflow) begin
            r_sticky_ovf <= 1'b1;
        end else if (sticky_clr) begin
            r_sticky_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/alu_wb_stage.md
# alu_wb_stage

Writeback stage directly downstream of the integer ALU. It accepts each ALU result with its flags and destination register over a valid/ready handshake, and buffers it in a 2-entry skid buffer. It presents the buffered results to the register-file write port in order. It also keeps an architectural flag register and a retire counter.

## Interface
Parameters:
- `WIDTH`, 4: datapath width; matches the ALU's `WIDTH`.
- `RD_W`, 5: destination register index width.
- `CNT_W`, 16: retire counter width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `in_valid`  in  1  ALU result valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_sel`  in  3  ALU opcode that produced the result.
- `in_rd`  in  RD_W  destination register index.
- `in_result`  in  WIDTH  ALU result.
- `in_overflow` / `in_carry` / `in_zero`  in  1 each  ALU flags.
- `wb_valid`  out  1  write request to the register file.
- `wb_ready`  in  1  register file accepts the write.
- `wb_rd`  out  RD_W  write index.
- `wb_data`  out  WIDTH  write data.
- `flags`  out  3  architectural flags {overflow, carry, zero}.
- `retire_cnt`  out  CNT_W  number of completed writebacks.
- `sticky_clr`  in  1  clears the sticky overflow bit (only with the macro).
- `sticky_ovf`  out  1  sticky overflow (only with the macro).

## Operation
- Accept: `in_valid & in_ready`. Write: `wb_valid & wb_ready`.
- Buffer: a main entry drives the `wb_*` outputs; a skid entry absorbs one result when the consumer stalls.
- `in_ready` is registered and equals `~skid_valid`.
- On accept with `in_rd != 0`:
  - If the main entry is empty, or is being written this cycle with the skid entry empty, the result loads into the main entry.
  - Otherwise the result loads into the skid entry.
- When the main entry is written and the skid entry holds data, the skid entry moves into the main entry in the same cycle.
- On accept with `in_rd == 0`: the result is consumed and never buffered; flags still update.
- Flag update happens on accept, not on write:
  - `in_sel` of 000, 001, 110 or 111: `flags <= {in_overflow, in_carry, in_zero}`.
  - `in_sel` of 010 through 101 (logic ops): `flags` are unchanged.
- `retire_cnt` increments by 1 on each write and wraps from all-ones to 0. Discarded `rd == 0` results are not counted.
- Ordering: writes leave strictly in acceptance order.
- Reset (any cycle, including with entries in flight): both entries invalid and their contents discarded, `wb_valid=0`, `in_ready=1`, `wb_rd=0`, `wb_data=0`, `flags=0`, `retire_cnt=0`, `sticky_ovf=0`.

## Timing
- Latency: accept in cycle N gives `wb_valid=1` in cycle N+1 with the matching data.
- Throughput: one result per cycle when `wb_ready` is held high.
- Stall: with `wb_ready=0`, two results are accepted. `in_ready` falls in the cycle after the second accept.
- Recovery: after the first write following a stall, `in_ready` returns high one cycle later.
- `wb_*` outputs are register outputs and stay stable while `wb_valid & ~wb_ready`.
- `flags` reflects an accepted result starting in the next cycle.
- No combinational path from `wb_ready` to `in_ready`.

## Configuration
- Macro `ALU_WB_STICKY_OVF_EN`.
- Defined:
  - `sticky_ovf` sets on any accept whose opcode updates flags and whose `in_overflow=1`.
  - `sticky_ovf` clears on `sticky_clr`. When set and clear happen in the same cycle, set wins.
- Undefined: the `sticky_ovf` and `sticky_clr` ports and their logic are absent.

## Structure
- Shared package `alu_pkg` holds:
  - the opcode constants `ALU_ADD=3'b000`, `ALU_SUB=3'b001`, `ALU_NOT=3'b010`, `ALU_AND=3'b011`, `ALU_OR=3'b100`, `ALU_XOR=3'b101`, `ALU_SLT=3'b110`, `ALU_EQ=3'b111`;
  - the `alu_flags_t` struct {overflow, carry, zero};
  - the function `alu_sets_flags(sel)`.
- One sub-module, `skid_buf2`, parameterised on payload width, carries {rd, result}. Flags, counter and sticky logic live in the top.

## Test plan
- Reset while both entries are full -> next cycle `wb_valid=0`, `in_ready=1`, `flags=0`, `retire_cnt=0`.
- Back-to-back accepts of ADD rd=3 result 4'h5, then SUB rd=4 result 4'hF with carry=1, `wb_ready=1` -> writes (3,5) then (4,F) in consecutive cycles; `flags=3'b010` after the second.
- Hold `wb_ready=0` and offer 3 results -> 2 accepted, `in_ready=0` from the cycle after the second accept; release `wb_ready` -> writes in order, third accepted one cycle after the first write.
- AND rd=0 with `in_zero=1` after an ADD that set flags 3'b100 -> no write, `retire_cnt` unchanged, `flags` stay 3'b100.
- `retire_cnt` preloaded near wrap via 2^CNT_W writes -> reads 0 after the wrap.
- Macro defined: ADD with overflow=1 sets `sticky_ovf`; a following non-overflowing op leaves it 1; `sticky_clr` -> 0; `sticky_clr` in the same cycle as an overflowing accept -> stays 1.
